// File: rtl/sram_resp_pkg.sv
// rtl/sram_resp_pkg.sv - shared constants and byte-lane helper for the SRAM responder
package sram_resp_pkg;

  localparam logic [15:0] CONF_HI_DEF = 16'hBFAF;

  localparam logic [15:0] OFF_LED    = 16'hF000;
  localparam logic [15:0] OFF_SWITCH = 16'hF010;
  localparam logic [15:0] OFF_TIMER  = 16'hE000;

  // Lane i of the result comes from new_w when be[i] is set, otherwise from old_w.
  function automatic logic [31:0] merge_be(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_dp_be.sv
// rtl/sram_dp_be.sv - dual-port word RAM: port A read-only, port B byte-enabled read/write
// Reads are registered and return the pre-write word when both ports hit the same address.
import sram_resp_pkg::*;

module sram_dp_be #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [31:0]       a_rdata,
  input  logic              b_en,
  input  logic [3:0]        b_wen,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic [31:0]       b_rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic        b_we;
  logic        b_re;

  // Writes are held off while reset is asserted so a stalled store cannot land.
  assign b_we = b_en && (b_wen != 4'h0) && !rst;
  assign b_re = b_en && (b_wen == 4'h0);

  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= merge_be(mem[b_addr], b_wdata, b_wen);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata <= 32'h0;
      b_rdata <= 32'h0;
    end else begin
      if (a_en) a_rdata <= mem[a_addr];
      if (b_re) b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/sram_resp_dual.sv
// rtl/sram_resp_dual.sv - inst/data SRAM responder with LED, switch and timer config window
import sram_resp_pkg::*;

module sram_resp_dual #(
  parameter int          ADDR_W  = 12,
  parameter logic [15:0] CONF_HI = CONF_HI_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led_out
);

  logic        cfg;
  logic [15:0] off;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] ram_b_rdata;
  logic [31:0] timer;
  logic [15:0] led;
  logic [31:0] led_merge;
  logic [31:0] cfg_rdata_d;
  logic [31:0] cfg_rdata_q;
  logic        rd_cfg_q;
  logic        unused_bits;

  assign cfg  = (data_sram_addr[31:16] == CONF_HI);
  assign off  = data_sram_addr[15:0];
  assign d_rd = data_sram_en && (data_sram_wen == 4'h0);
  assign d_wr = data_sram_en && (data_sram_wen != 4'h0);

  sram_dp_be #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .a_en    (inst_sram_en),
    .a_addr  (inst_sram_addr[ADDR_W+1:2]),
    .a_rdata (inst_sram_rdata),
    .b_en    (data_sram_en && !cfg),
    .b_wen   (data_sram_wen),
    .b_addr  (data_sram_addr[ADDR_W+1:2]),
    .b_wdata (data_sram_wdata),
    .b_rdata (ram_b_rdata)
  );

  // LED only owns lanes 0-1; upper lanes of the store are discarded.
  assign led_merge = merge_be({16'h0, led}, data_sram_wdata, {2'b00, data_sram_wen[1:0]});

  always_comb begin
    cfg_rdata_d = 32'h0;
    case (off)
      OFF_LED:    cfg_rdata_d = {16'h0, led};
      OFF_SWITCH: cfg_rdata_d = {16'h0, switch_in};
      OFF_TIMER:  cfg_rdata_d = timer;
      default:    cfg_rdata_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer       <= 32'h0;
      led         <= 16'h0;
      cfg_rdata_q <= 32'h0;
      rd_cfg_q    <= 1'b0;
    end else begin
      if (d_wr && cfg && (off == OFF_LED)) led <= led_merge[15:0];
      if (d_wr && cfg && (off == OFF_TIMER)) timer <= merge_be(timer, data_sram_wdata, data_sram_wen);
      else                                   timer <= timer + 32'd1;
      // The source select only moves on reads, so a store leaves the last read value visible.
      if (d_rd) begin
        rd_cfg_q <= cfg;
        if (cfg) cfg_rdata_q <= cfg_rdata_d;
      end
    end
  end

  assign data_sram_rdata = rd_cfg_q ? cfg_rdata_q : ram_b_rdata;
  assign led_out         = led;

  assign unused_bits = ^{inst_sram_addr[31:ADDR_W+2], inst_sram_addr[1:0], led_merge[31:16]};

endmodule

// File: tb/tb_sram_resp_dual.sv
// tb/tb_sram_resp_dual.sv - directed bench with a behavioural memory/register model
module tb_sram_resp_dual;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] switch_in;
  logic [15:0] led_out;

  always #5 clk = ~clk;

  sram_resp_dual dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch_in       (switch_in),
    .led_out         (led_out)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_mem [int];
  logic [31:0] m_inst  = 32'h0;
  logic [31:0] m_data  = 32'h0;
  logic [31:0] m_timer = 32'h0;
  logic [15:0] m_led   = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_inst", inst_sram_rdata, m_inst);
      check("cmp_data", data_sram_rdata, m_data);
      check("cmp_led", {16'h0, led_out}, {16'h0, m_led});
    end
  end

  function automatic int widx(input logic [31:0] a);
    return int'(a >> 2) % 4096;
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (m_mem.exists(widx(a))) return m_mem[widx(a)];
    return 32'hxxxxxxxx;
  endfunction

  task automatic model_zero();
    m_inst = 32'h0; m_data = 32'h0; m_led = 16'h0; m_timer = 32'h0;
  endtask

  // What one clock edge does to the visible state, stated from the memory-map rules.
  task automatic model_edge();
    logic [31:0] t0;
    logic [31:0] w;
    if (rst) begin
      model_zero();
      return;
    end
    t0 = m_timer;
    m_timer = t0 + 32'd1;
    if (inst_sram_en) m_inst = rd_mem(inst_sram_addr);
    if (data_sram_en) begin
      if (data_sram_addr[31:16] == 16'hBFAF) begin
        if (data_sram_wen == 4'h0) begin
          if (data_sram_addr[15:0] == 16'hF000)      m_data = {16'h0, m_led};
          else if (data_sram_addr[15:0] == 16'hF010) m_data = {16'h0, switch_in};
          else if (data_sram_addr[15:0] == 16'hE000) m_data = t0;
          else                                       m_data = 32'h0;
        end else if (data_sram_addr[15:0] == 16'hF000) begin
          for (int i = 0; i < 2; i++)
            if (data_sram_wen[i]) m_led[8*i +: 8] = data_sram_wdata[8*i +: 8];
        end else if (data_sram_addr[15:0] == 16'hE000) begin
          w = t0;
          for (int i = 0; i < 4; i++)
            if (data_sram_wen[i]) w[8*i +: 8] = data_sram_wdata[8*i +: 8];
          m_timer = w;
        end
      end else if (data_sram_wen == 4'h0) begin
        m_data = rd_mem(data_sram_addr);
      end else begin
        w = rd_mem(data_sram_addr);
        for (int i = 0; i < 4; i++)
          if (data_sram_wen[i]) w[8*i +: 8] = data_sram_wdata[8*i +: 8];
        m_mem[widx(data_sram_addr)] = w;
      end
    end
  endtask

  task automatic drive(input logic ie, input logic [31:0] ia, input logic de,
                       input logic [3:0] we, input logic [31:0] da, input logic [31:0] wd);
    inst_sram_en = ie; inst_sram_addr = ia;
    data_sram_en = de; data_sram_wen = we; data_sram_addr = da; data_sram_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  initial begin
    idle();
    switch_in = 16'h0;
    #1 rst = 1'b1;
    model_zero();
    #1 chk_en = 1'b1;
    check("rst_inst", inst_sram_rdata, 32'h0);
    check("rst_data", data_sram_rdata, 32'h0);
    check("rst_led", {16'h0, led_out}, 32'h0);
    tick(); tick();
    rst = 1'b0;

    drive(1'b0, 32'h0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF); tick();
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0);        tick();
    check("raw_lit", data_sram_rdata, 32'hDEADBEEF);

    drive(1'b0, 32'h0, 1'b1, 4'hF,    32'h14, 32'h11223344); tick();
    drive(1'b0, 32'h0, 1'b1, 4'b0101, 32'h14, 32'hAABBCCDD); tick();
    check("wr_hold_lit", data_sram_rdata, 32'hDEADBEEF);
    drive(1'b0, 32'h0, 1'b1, 4'h0,    32'h14, 32'h0);        tick();
    check("be_merge_lit", data_sram_rdata, 32'h11BB33DD);

    drive(1'b0, 32'h0,  1'b1, 4'hF, 32'h20, 32'h00000001); tick();
    drive(1'b1, 32'h20, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D); tick();
    check("rbw_old_lit", inst_sram_rdata, 32'h00000001);
    drive(1'b1, 32'h20, 1'b0, 4'h0, 32'h0, 32'h0); tick();
    check("rbw_new_lit", inst_sram_rdata, 32'hCAFEF00D);

    switch_in = 16'h00F0;
    drive(1'b0, 32'h0, 1'b1, 4'hF, 32'hBFAFF000, 32'h0000A5A5); tick();
    check("led_lit", {16'h0, led_out}, 32'h0000A5A5);
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'hBFAFF010, 32'h0); tick();
    check("switch_lit", data_sram_rdata, 32'h000000F0);
    drive(1'b0, 32'h0, 1'b1, 4'hF, 32'hBFAFF010, 32'h00001234); tick();
    check("switch_wr_lit", data_sram_rdata, 32'h000000F0);
    check("switch_wr_led_lit", {16'h0, led_out}, 32'h0000A5A5);
    drive(1'b0, 32'h0, 1'b1, 4'b1110, 32'hBFAFF000, 32'hFFFF3C00); tick();
    check("led_mask_lit", {16'h0, led_out}, 32'h00003CA5);
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'hBFAFF000, 32'h0); tick();
    check("led_rd_lit", data_sram_rdata, 32'h00003CA5);

    drive(1'b0, 32'h0, 1'b1, 4'hF, 32'hBFAFE000, 32'hFFFFFFFE); tick();
    idle(); tick();
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'hBFAFE000, 32'h0); tick();
    check("timer_ff_lit", data_sram_rdata, 32'hFFFFFFFF);
    tick();
    check("timer_wrap_lit", data_sram_rdata, 32'h00000000);
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'hBFAF0004, 32'h0); tick();
    check("unmapped_lit", data_sram_rdata, 32'h0);

    drive(1'b0, 32'h0, 1'b1, 4'hF, 32'h00004010, 32'h55667788); tick();
    drive(1'b1, 32'h4012, 1'b1, 4'h0, 32'h13, 32'h0); tick();
    check("alias_data_lit", data_sram_rdata, 32'h55667788);
    check("alias_inst_lit", inst_sram_rdata, 32'h55667788);
    drive(1'b0, 32'h20, 1'b0, 4'hF, 32'h10, 32'h0); tick(); tick();
    check("en0_hold_lit", inst_sram_rdata, 32'h55667788);

    drive(1'b1, 32'h20, 1'b1, 4'h0, 32'h14, 32'h0); tick();
    drive(1'b1, 32'h10, 1'b1, 4'hF, 32'h14, 32'h0BADF00D);
    #1 rst = 1'b1;
    model_zero();
    #1;
    check("midrst_inst_lit", inst_sram_rdata, 32'h0);
    check("midrst_data_lit", data_sram_rdata, 32'h0);
    check("midrst_led_lit", {16'h0, led_out}, 32'h0);
    tick(); tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 4'h0, 32'hBFAFE000, 32'h0); tick();
    check("rst_timer0_lit", data_sram_rdata, 32'h0);
    tick();
    check("rst_timer1_lit", data_sram_rdata, 32'h1);
    drive(1'b1, 32'h20, 1'b1, 4'h0, 32'h14, 32'h0); tick();
    check("rst_ram_keep_lit", data_sram_rdata, 32'h11BB33DD);
    check("rst_inst_keep_lit", inst_sram_rdata, 32'hCAFEF00D);
    idle(); tick(); tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
